// File: rtl/spi_main_if.sv
// Host-side command/response bus of the SPI controller.
// The host issues a one-cycle start with cmd/wr_data and sees busy/done/err/rd_data come back.
interface spi_main_if;
    logic         start;
    logic [4:0]   cmd;
    logic [127:0] wr_data;
    logic [127:0] rd_data;
    logic         busy;
    logic         done;
    logic         err;

    modport master (output start, cmd, wr_data, input rd_data, busy, done, err);
    modport slave  (input start, cmd, wr_data, output rd_data, busy, done, err);
endinterface

// File: rtl/spi_main.sv
// SPI controller for the ASCON SPI subnode: one start strobe becomes one framed transaction
// (CSB low, 5-bit command, 128/64/3 payload bits, CSB high), with MISO captured on reads.
module spi_main #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_main_if.slave host,
    output logic      sck,
    output logic      csb,
    output logic      mosi,
    input  logic      miso
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t       state_q, state_d;
    logic [7:0]   div_q, div_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   len_q, len_d;
    logic [4:0]   cmd_q, cmd_d;
    logic [127:0] wr_q, wr_d;
    logic [127:0] rd_q, rd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         sck_q, sck_d;
    logic         csb_q, csb_d;
    logic         mosi_q, mosi_d;
    logic         tick;

    function automatic logic cmd_legal(input logic [3:0] c);
        cmd_legal = (c <= 4'd8);
    endfunction

    function automatic logic [7:0] payload_len(input logic [3:0] c);
        case (c)
            4'd0, 4'd1, 4'd2: payload_len = 8'd128;
            4'd3:             payload_len = 8'd3;
            default:          payload_len = 8'd64;
        endcase
    endfunction

    // Bit presented on MOSI ahead of rising edge k+1 (k counts rises already done).
    function automatic logic frame_bit(input logic [7:0] k, input logic [4:0] c,
                                       input logic [7:0] n, input logic [127:0] w);
        logic [2:0] cidx;
        logic [6:0] widx;
        cidx      = 3'd4 - k[2:0];
        widx      = 7'(n + 8'd4 - k);
        frame_bit = 1'b0;
        if (k < 8'd5) begin
            frame_bit = c[cidx];
        end else if (!c[4] && (k < n + 8'd5)) begin
            frame_bit = w[widx];
        end
    endfunction

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = (state_q == S_IDLE || tick) ? 8'd0 : div_q + 8'd1;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sck_d     = sck_q;
        csb_d     = csb_q;
        mosi_d    = mosi_q;

        case (state_q)
            S_IDLE: begin
                sck_d = 1'b0;
                csb_d = 1'b1;
                if (host.start) begin
                    if (cmd_legal(host.cmd[3:0])) begin
                        cmd_d     = host.cmd;
                        len_d     = payload_len(host.cmd[3:0]);
                        wr_d      = host.wr_data;
                        rd_d      = '0;
                        bit_cnt_d = 8'd0;
                        busy_d    = 1'b1;
                        csb_d     = 1'b0;
                        mosi_d    = host.cmd[4];
                        div_d     = 8'd0;
                        state_d   = S_LEAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LEAD: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    sck_d     = 1'b0;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    mosi_d    = frame_bit(bit_cnt_q + 8'd1, cmd_q, len_q, wr_q);
                    // MISO was updated one clk after the rise, so it is settled here.
                    if (cmd_q[4] && bit_cnt_q >= 8'd5) begin
                        rd_d = {rd_q[126:0], miso};
                    end
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (tick) begin
                    if (bit_cnt_q < len_q + 8'd5) begin
                        sck_d   = 1'b1;
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (tick) begin
                    csb_d   = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                sck_d   = 1'b0;
                csb_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= 8'd0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sck_q     <= 1'b0;
            csb_q     <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sck_q     <= sck_d;
            csb_q     <= csb_d;
            mosi_q    <= mosi_d;
        end
    end

    // Latched command and payload are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        len_q <= len_d;
        cmd_q <= cmd_d;
        wr_q  <= wr_d;
    end

    assign host.rd_data = rd_q;
    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.err     = err_q;
    assign sck          = sck_q;
    assign csb          = csb_q;
    assign mosi         = mosi_q;
endmodule
